// File: rtl/sort_controller_param_if.sv
// Handshake and strobe bundle between the sort controller and its PE array / requester.
interface sort_controller_param_if #(
    parameter int unsigned CW = 3
);
    logic          en;
    logic          abort;
    logic          early_exit_en;
    logic          swap_any;
    logic          write_enable;
    logic          even_SL;
    logic          even_SR;
    logic          even_RL;
    logic          even_RR;
    logic          odd_SL;
    logic          odd_SR;
    logic          odd_RL;
    logic          odd_RR;
    logic          odd_cmp_en;
    logic          even_cmp_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] rounds_done;

    // Requester / PE-array side.
    modport master (
        output en, abort, early_exit_en, swap_any,
        input  write_enable, even_SL, even_SR, even_RL, even_RR,
               odd_SL, odd_SR, odd_RL, odd_RR, odd_cmp_en, even_cmp_en,
               busy, done, rounds_done
    );

    // Controller side.
    modport slave (
        input  en, abort, early_exit_en, swap_any,
        output write_enable, even_SL, even_SR, even_RL, even_RR,
               odd_SL, odd_SR, odd_RL, odd_RR, odd_cmp_en, even_cmp_en,
               busy, done, rounds_done
    );
endinterface

// File: rtl/sort_controller_param.sv
// Odd-even transposition sort sequencer: steps a PE array through send/receive/compare
// phases, counts rounds and optionally stops after a round without any swap.
module sort_controller_param #(
    parameter int unsigned CMP_CYCLES = 6,
    parameter int unsigned ROUNDS     = 4,
    parameter int unsigned CW         = $clog2(ROUNDS + 1)
) (
    input logic                     clk,
    input logic                     rst,
    sort_controller_param_if.slave  bus
);

    localparam int unsigned CMPW = (CMP_CYCLES > 1) ? $clog2(CMP_CYCLES) : 1;
    localparam logic [CMPW-1:0] CMP_LAST   = CMPW'(CMP_CYCLES - 1);
    localparam logic [CW-1:0]   ROUNDS_CW  = CW'(ROUNDS);

    typedef enum logic [7:0] {
        IDLE           = 8'b0000_0001,
        EVEN_SL_ODD_RR = 8'b0000_0010,
        ODD_COMPARE    = 8'b0000_0100,
        EVEN_RL_ODD_SR = 8'b0000_1000,
        EVEN_RR_ODD_SL = 8'b0001_0000,
        EVEN_COMPARE   = 8'b0010_0000,
        EVEN_SR_ODD_RL = 8'b0100_0000,
        DONE           = 8'b1000_0000
    } state_e;

    state_e          state_q, state_d;
    logic [CMPW-1:0] cmp_q, cmp_d;
    logic [CW-1:0]   round_q, round_d;
    logic            swap_q, swap_d;

    logic write_enable_q;
    logic even_sl_q, even_sr_q, even_rl_q, even_rr_q;
    logic odd_sl_q, odd_sr_q, odd_rl_q, odd_rr_q;
    logic odd_cmp_q, even_cmp_q, busy_q, done_q;

    // Next-state, compare/round counters and swap tracking.
    always_comb begin
        state_d = state_q;
        cmp_d   = cmp_q;
        round_d = round_q;
        swap_d  = swap_q;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            cmp_d   = '0;
            round_d = '0;
            swap_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en && !bus.abort) begin
                        state_d = EVEN_SL_ODD_RR;
                        round_d = '0;
                        swap_d  = 1'b0;
                    end
                end
                EVEN_SL_ODD_RR: begin
                    state_d = ODD_COMPARE;
                    cmp_d   = '0;
                end
                ODD_COMPARE: begin
                    swap_d = swap_q | bus.swap_any;
                    if (cmp_q == CMP_LAST) begin
                        state_d = EVEN_RL_ODD_SR;
                    end else begin
                        cmp_d = cmp_q + CMPW'(1);
                    end
                end
                EVEN_RL_ODD_SR: state_d = EVEN_RR_ODD_SL;
                EVEN_RR_ODD_SL: begin
                    state_d = EVEN_COMPARE;
                    cmp_d   = '0;
                end
                EVEN_COMPARE: begin
                    swap_d = swap_q | bus.swap_any;
                    if (cmp_q == CMP_LAST) begin
                        state_d = EVEN_SR_ODD_RL;
                    end else begin
                        cmp_d = cmp_q + CMPW'(1);
                    end
                end
                EVEN_SR_ODD_RL: begin
                    round_d = round_q + CW'(1);
                    if (round_d == ROUNDS_CW || (bus.early_exit_en && !swap_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = EVEN_SL_ODD_RR;
                        swap_d  = 1'b0;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cmp_q          <= '0;
            round_q        <= '0;
            swap_q         <= 1'b0;
            write_enable_q <= 1'b1;
            even_sl_q      <= 1'b0;
            even_sr_q      <= 1'b0;
            even_rl_q      <= 1'b0;
            even_rr_q      <= 1'b0;
            odd_sl_q       <= 1'b0;
            odd_sr_q       <= 1'b0;
            odd_rl_q       <= 1'b0;
            odd_rr_q       <= 1'b0;
            odd_cmp_q      <= 1'b0;
            even_cmp_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmp_q          <= cmp_d;
            round_q        <= round_d;
            swap_q         <= swap_d;
            write_enable_q <= (state_d == IDLE);
            even_sl_q      <= (state_d == EVEN_SL_ODD_RR);
            odd_rr_q       <= (state_d == EVEN_SL_ODD_RR);
            odd_cmp_q      <= (state_d == ODD_COMPARE);
            even_rl_q      <= (state_d == EVEN_RL_ODD_SR);
            odd_sr_q       <= (state_d == EVEN_RL_ODD_SR);
            even_rr_q      <= (state_d == EVEN_RR_ODD_SL);
            odd_sl_q       <= (state_d == EVEN_RR_ODD_SL);
            even_cmp_q     <= (state_d == EVEN_COMPARE);
            even_sr_q      <= (state_d == EVEN_SR_ODD_RL);
            odd_rl_q       <= (state_d == EVEN_SR_ODD_RL);
            busy_q         <= (state_d != IDLE);
            done_q         <= (state_d == DONE);
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.even_SL      = even_sl_q;
    assign bus.even_SR      = even_sr_q;
    assign bus.even_RL      = even_rl_q;
    assign bus.even_RR      = even_rr_q;
    assign bus.odd_SL       = odd_sl_q;
    assign bus.odd_SR       = odd_sr_q;
    assign bus.odd_RL       = odd_rl_q;
    assign bus.odd_RR       = odd_rr_q;
    assign bus.odd_cmp_en   = odd_cmp_q;
    assign bus.even_cmp_en  = even_cmp_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rounds_done  = round_q;

endmodule

// File: doc/sort_controller_param.md
SORT_CONTROLLER_PARAM -- requirements
Module: sort_controller_param

Interface
REQ-001 Parameter CMP_CYCLES, default 6, SHALL set cycles per compare phase; legal values are 1 to 255.
REQ-002 Parameter ROUNDS, default 4, SHALL set maximum odd+even rounds per sort; legal values are 1 to 255.
REQ-003 Parameter CW, default $clog2(ROUNDS+1), SHALL set the width of rounds_done.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  start request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of an active sort.
REQ-008 early_exit_en  in  1  enables termination after a swap-free round.
REQ-009 swap_any  in  1  OR of all PE swap flags; meaningful only while a cmp_en strobe is high.
REQ-010 write_enable  out  1  PE array may load unsorted data.
REQ-011 even_SL, even_SR, even_RL, even_RR, odd_SL, odd_SR, odd_RL, odd_RR  out  1 each  PE send/receive-left/right strobes.
REQ-012 odd_cmp_en, even_cmp_en  out  1 each  compare enables.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 rounds_done  out  CW  count of completed rounds; held from done until the next accepted start.

Function
REQ-016 The FSM states SHALL be IDLE, EVEN_SL_ODD_RR, ODD_COMPARE, EVEN_RL_ODD_SR, EVEN_RR_ODD_SL, EVEN_COMPARE, EVEN_SR_ODD_RL, DONE (one-hot).
REQ-017 Transitions SHALL be:
- IDLE->EVEN_SL_ODD_RR on en.
- EVEN_SL_ODD_RR->ODD_COMPARE.
- ODD_COMPARE->EVEN_RL_ODD_SR after exactly CMP_CYCLES cycles.
- EVEN_RL_ODD_SR->EVEN_RR_ODD_SL->EVEN_COMPARE.
- EVEN_COMPARE->EVEN_SR_ODD_RL after exactly CMP_CYCLES cycles.
- EVEN_SR_ODD_RL->DONE or EVEN_SL_ODD_RR per REQ-021.
- DONE->IDLE unconditionally.
REQ-018 All outputs SHALL be registered and decoded from next state, so each strobe is high in exactly the cycles the FSM occupies its state.
REQ-019 Per-state strobes SHALL be:
- EVEN_SL_ODD_RR: even_SL, odd_RR.
- ODD_COMPARE: odd_cmp_en.
- EVEN_RL_ODD_SR: even_RL, odd_SR.
- EVEN_RR_ODD_SL: even_RR, odd_SL.
- EVEN_COMPARE: even_cmp_en.
- EVEN_SR_ODD_RL: even_SR, odd_RL.
- IDLE: write_enable only.
- DONE: done only.
- All other outputs are 0 in each of these states.
REQ-020 A swap_seen flag SHALL be cleared on entry to EVEN_SL_ODD_RR and SHALL be set by swap_any=1 in any cycle where odd_cmp_en or even_cmp_en is high, including the last compare cycle.
REQ-021 In EVEN_SR_ODD_RL:
- The round counter SHALL increment.
- The next state SHALL be DONE if the counter reaches ROUNDS, or if early_exit_en=1 and swap_seen=0.
- Otherwise the next state SHALL be EVEN_SL_ODD_RR.
REQ-022 One round SHALL last 2*CMP_CYCLES+4 cycles. With en accepted at edge t, done SHALL be high in cycle t+1+R*(2*CMP_CYCLES+4), where R is the number of rounds executed.
REQ-023 rounds_done SHALL equal R during done and afterwards. It SHALL clear to 0 when a new start is accepted.
REQ-024 en SHALL be ignored when the FSM is not in IDLE. In DONE, en is not sampled; a start needs en high in IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge:
- done stays 0.
- write_enable returns to 1.
- rounds_done is cleared to 0.
REQ-026 If abort and en are high together in IDLE, the FSM SHALL stay in IDLE (abort wins).
REQ-027 The compare-cycle counter SHALL be reset to 0 on every entry to a compare state and SHALL never wrap within a phase.

Reset
REQ-028 rst=1 SHALL, from any state and mid-sort included, at the next edge:
- force IDLE.
- clear the round counter, compare counter, swap_seen and rounds_done.
- drive every strobe, busy and done to 0.
- drive write_enable to 1.
REQ-029 rst SHALL take priority over abort and en.

Verification
REQ-030 The bench SHALL cover:
- Reset: rst high 2 cycles, then low -> write_enable=1, busy=0, all strobes 0.
- Full sort, defaults, swap_any=1, en pulse at t:
  - even_SL/odd_RR high at t+1.
  - odd_cmp_en high t+2..t+7.
  - even_RL/odd_SR at t+8, even_RR/odd_SL at t+9.
  - even_cmp_en high t+10..t+15, even_SR/odd_RL at t+16.
  - done at t+65; rounds_done=4.
- Early exit, defaults, early_exit_en=1, swap_any=0 -> done at t+17, rounds_done=1. Same run with swap_any=1 for one cycle of round 1 -> done at t+33, rounds_done=2.
- Abort during EVEN_COMPARE of round 2 -> IDLE next cycle, write_enable=1, no done pulse. rst asserted mid-ODD_COMPARE -> same result.
- en pulses while busy -> no effect on sequence or done timing.
- en with abort in IDLE -> no start.
- CMP_CYCLES=1, ROUNDS=1 -> done at t+7.
